keypad_scan_fifo: RTL and testbench

Parametrised matrix-keypad scanner and the successor to the fixed 4x4 keypad block. It drives active-low columns and samples active-low rows. It debounces a whole scan frame at a time and emits press and release events into a key-event FIFO. A level IRQ is raised while the FIFO holds events. It sits behind the AXI-lite keypad IP wrapper, which pops events and reads status.

---
 rtl/keypad_scan_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_fifo.sv
// rtl/keypad_scan_fifo.sv - matrix keypad scanner with frame debounce and key-event FIFO
module keypad_scan_fifo #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 16,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic [ROWS-1:0]               iROW,
    output logic [COLS-1:0]               oCOL,
    output logic [ROWS*COLS-1:0]          oKEYST,
    input  logic                          iPOP,
    output logic [7:0]                    oKEYDATA,
    output logic                          oVALID,
    output logic [$clog2(FIFO_DEPTH):0]   oCOUNT,
    output logic                          oOVF,
    input  logic                          iOVF_CLR,
    input  logic                          iIRQ_EN,
    output logic                          oIRQ
);

    localparam int NKEYS = ROWS * COLS;
    localparam int CW    = $clog2(COLS);
    localparam int DW    = $clog2(SCAN_DIV);
    localparam int SW    = $clog2(DEBOUNCE + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int IW    = $clog2(NKEYS);

    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);
    localparam logic [6:0]    IDX_LAST   = 7'(NKEYS - 1);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic {SCAN, COMMIT} state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     col;
    logic [DW-1:0]     dwell;
    logic [NKEYS-1:0]  raw;
    logic [NKEYS-1:0]  raw_next;
    logic [NKEYS-1:0]  prev;
    logic [NKEYS-1:0]  keyst;
    logic [NKEYS-1:0]  diff;
    logic [SW-1:0]     stable;
    logic [SW-1:0]     stable_next;
    logic [6:0]        idx;
    logic [IW-1:0]     idx_s;
    logic              capture;
    logic              frame_end;
    logic              start_commit;
    logic              push;
    logic [7:0]        push_data;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW:0]       count;
    logic              full;
    logic              pop;
    logic              do_write;
    logic              drop;
    logic              ovf;
    logic              irq;

    assign idx_s = idx[IW-1:0];

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        capture      = 1'b0;
        frame_end    = 1'b0;
        start_commit = 1'b0;
        push         = 1'b0;
        push_data    = {keyst[idx_s], idx};
        raw_next     = raw;
        stable_next  = stable;
        oCOL         = '1;
        case (state)
            SCAN: begin
                oCOL = ~(COLS'(1) << col);
                if (dwell == DWELL_LAST) begin
                    capture = 1'b1;
                    for (int k = 0; k < NKEYS; k++) begin
                        if ((k % COLS) == int'(col)) begin
                            raw_next[k] = ~iROW[k / COLS];
                        end
                    end
                    // The whole frame is judged once the last column has been sampled.
                    if (col == COL_LAST) begin
                        frame_end = 1'b1;
                        if (raw_next != prev) begin
                            stable_next = '0;
                        end else if (stable != STABLE_MAX) begin
                            stable_next = stable + 1'b1;
                        end
                        if (stable_next == STABLE_MAX && raw_next != keyst) begin
                            start_commit = 1'b1;
                            state_next   = COMMIT;
                        end
                    end
                end
            end
            COMMIT: begin
                push = diff[idx_s];
                if (idx == IDX_LAST) begin
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col    <= '0;
            dwell  <= '0;
            raw    <= '0;
            prev   <= '0;
            keyst  <= '0;
            diff   <= '0;
            stable <= '0;
            idx    <= '0;
        end else begin
            raw    <= raw_next;
            stable <= stable_next;
            if (state == SCAN) begin
                if (capture) begin
                    dwell <= '0;
                    col   <= (col == COL_LAST) ? '0 : col + 1'b1;
                end else begin
                    dwell <= dwell + 1'b1;
                end
                if (frame_end) begin
                    prev <= raw_next;
                end
                if (start_commit) begin
                    diff  <= raw_next ^ keyst;
                    keyst <= raw_next;
                    idx   <= '0;
                end
            end else begin
                idx <= idx + 1'b1;
                if (state_next == SCAN) begin
                    col   <= '0;
                    dwell <= '0;
                end
            end
        end
    end

    // A pop frees the head slot, so a push into a full FIFO still lands when paired with a pop.
    assign full     = (count == FULL_COUNT);
    assign pop      = iPOP & oVALID;
    assign do_write = push & (~full | pop);
    assign drop     = push & full & ~pop;

    always_ff @(posedge iCLK) begin
        if (do_write) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (iOVF_CLR) begin
                ovf <= 1'b0;
            end
            irq <= oVALID & iIRQ_EN;
        end
    end

    assign oVALID   = (count != '0);
    assign oKEYDATA = oVALID ? mem[rd_ptr] : 8'h00;
    assign oCOUNT   = count;
    assign oKEYST   = keyst;
    assign oOVF     = ovf;
    assign oIRQ     = irq;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb/tb_keypad_scan_fifo.sv - frame-level model bench for keypad_scan_fifo
module tb_keypad_scan_fifo;

    localparam int DEB   = 2;
    localparam int LIMIT = 400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  row1, row2, col1, col2;
    logic [15:0] keyst1, keyst2;
    logic        pop1, pop2, ovf_clr, irq_en;
    logic [7:0]  data1, data2;
    logic        valid1, valid2, ovf1, ovf2, irq1, irq2;
    logic [3:0]  count1;
    logic [1:0]  count2;

    logic [15:0] m_prev, m_keyst;
    int          m_stable;
    logic [7:0]  q8[$];
    logic [7:0]  q2[$];
    bit          m_ovf8, m_ovf2, aligned;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign row1 = {~|(keys[15:12] & ~col1), ~|(keys[11:8] & ~col1),
                   ~|(keys[7:4] & ~col1), ~|(keys[3:0] & ~col1)};
    assign row2 = {~|(keys[15:12] & ~col2), ~|(keys[11:8] & ~col2),
                   ~|(keys[7:4] & ~col2), ~|(keys[3:0] & ~col2)};

    keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(2), .DEBOUNCE(DEB), .FIFO_DEPTH(8)) dut1 (
        .iCLK(clk), .iRST(rst_n), .iROW(row1), .oCOL(col1), .oKEYST(keyst1),
        .iPOP(pop1), .oKEYDATA(data1), .oVALID(valid1), .oCOUNT(count1), .oOVF(ovf1),
        .iOVF_CLR(ovf_clr), .iIRQ_EN(irq_en), .oIRQ(irq1));

    keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(2), .DEBOUNCE(DEB), .FIFO_DEPTH(2)) dut2 (
        .iCLK(clk), .iRST(rst_n), .iROW(row2), .oCOL(col2), .oKEYST(keyst2),
        .iPOP(pop2), .oKEYDATA(data2), .oVALID(valid2), .oCOUNT(count2), .oOVF(ovf2),
        .iOVF_CLR(ovf_clr), .iIRQ_EN(irq_en), .oIRQ(irq2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_prev = '0; m_keyst = '0; m_stable = 0;
        q8.delete(); q2.delete();
        m_ovf8 = 0; m_ovf2 = 0;
    endfunction

    function automatic void model_push(input logic [7:0] ev);
        if (q8.size() < 8) q8.push_back(ev); else m_ovf8 = 1;
        if (q2.size() < 2) q2.push_back(ev); else m_ovf2 = 1;
    endfunction

    // One complete frame with the matrix held at pat.
    function automatic void model_frame(input logic [15:0] pat, input bit pop_in_commit);
        if (pat != m_prev) m_stable = 0;
        else if (m_stable < DEB) m_stable++;
        m_prev = pat;
        if (m_stable == DEB && pat != m_keyst) begin
            if (pop_in_commit && q2.size() > 0) void'(q2.pop_front());
            for (int i = 0; i < 16; i++)
                if (pat[i] != m_keyst[i]) model_push({pat[i], 7'(i)});
            m_keyst = pat;
        end
    endfunction

    task automatic wait_end(input bit pop_c);
        int n = 0;
        while (col1 != 4'b0111 && n < LIMIT) begin @(negedge clk); n++; end
        while (col1 == 4'b0111 && n < LIMIT) begin @(negedge clk); n++; end
        if (col1 == 4'b1111) begin
            if (pop_c) begin
                if (q2.size() > 0) chk("commit_pop_head", data2, q2[0]);
                pop2 = 1'b1; @(negedge clk); pop2 = 1'b0; n++;
            end
            while (col1 != 4'b1110 && n < LIMIT) begin @(negedge clk); n++; end
        end
        chk("frame_in_budget", n < LIMIT, 1);
    endtask

    task automatic run_frame(input logic [15:0] pat, input bit pop_c);
        if (!aligned) begin
            wait_end(1'b0);
            model_frame(keys, 1'b0);
        end
        keys = pat;
        wait_end(pop_c);
        model_frame(pat, pop_c);
        aligned = 1;
    endtask

    task automatic check_state();
        chk("keyst1", keyst1, m_keyst);
        chk("keyst2", keyst2, m_keyst);
        chk("count1", count1, q8.size());
        chk("count2", count2, q2.size());
        chk("valid1", valid1, q8.size() != 0);
        chk("ovf1", ovf1, m_ovf8);
        chk("ovf2", ovf2, m_ovf2);
        if (q8.size() > 0) chk("head1", data1, q8[0]);
        if (q2.size() > 0) chk("head2", data2, q2[0]);
    endtask

    task automatic check_irq();
        @(negedge clk); @(negedge clk);
        chk("irq1", irq1, (q8.size() != 0) && irq_en);
        chk("irq2", irq2, (q2.size() != 0) && irq_en);
        aligned = 0;
    endtask

    task automatic drain(input int which);
        if (which == 1) begin
            while (q8.size() > 0) begin
                chk("pop_valid1", valid1, 1);
                chk("pop_data1", data1, q8[0]);
                void'(q8.pop_front());
                pop1 = 1'b1; @(negedge clk); pop1 = 1'b0;
                chk("pop_count1", count1, q8.size());
            end
        end else begin
            while (q2.size() > 0) begin
                chk("pop_valid2", valid2, 1);
                chk("pop_data2", data2, q2[0]);
                void'(q2.pop_front());
                pop2 = 1'b1; @(negedge clk); pop2 = 1'b0;
                chk("pop_count2", count2, q2.size());
            end
        end
        aligned = 0;
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        m_ovf8 = 0; m_ovf2 = 0;
        chk("ovf_clr1", ovf1, 0);
        chk("ovf_clr2", ovf2, 0);
        aligned = 0;
    endtask

    task automatic check_reset();
        chk("rst_col1", col1, 4'b1110);
        chk("rst_col2", col2, 4'b1110);
        chk("rst_keyst1", keyst1, 0);
        chk("rst_valid1", valid1, 0);
        chk("rst_count1", count1, 0);
        chk("rst_count2", count2, 0);
        chk("rst_data1", data1, 0);
        chk("rst_ovf2", ovf2, 0);
        chk("rst_irq1", irq1, 0);
    endtask

    initial begin
        logic [3:0]  exp_col;
        logic [15:0] pat;
        int          hold;

        rst_n = 1'b0; keys = '0; pop1 = 1'b0; pop2 = 1'b0; ovf_clr = 1'b0; irq_en = 1'b1;
        model_reset();
        aligned = 0;
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((n / 2) % 4));
            chk("col_rotate", col1, exp_col);
        end

        // single key at row0/col2, then release
        repeat (4) run_frame(16'h0004, 1'b0);
        check_state();
        check_irq();
        repeat (3) run_frame(16'h0000, 1'b0);
        check_state();
        drain(1);
        drain(2);

        // bounce: never stable for DEB frames
        for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? 16'h0010 : 16'h0000, 1'b0);
        check_state();

        // keys 1, 6, 15 together; the 2-deep FIFO overflows
        repeat (3) run_frame(16'h8042, 1'b0);
        check_state();
        drain(1);
        clear_ovf();

        // key 0 pressed while the 2-deep FIFO is full and popped during the push
        repeat (2) run_frame(16'h8043, 1'b0);
        run_frame(16'h8043, 1'b1);
        check_state();
        drain(1);
        drain(2);

        // reset in the middle of a commit
        repeat (2) run_frame(16'h0101, 1'b0);
        begin
            int n = 0;
            while (col1 != 4'b1111 && n < LIMIT) begin @(negedge clk); n++; end
            chk("commit_seen", n < LIMIT, 1);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        aligned = 1;
        keys = '0;
        repeat (3) run_frame(16'h0000, 1'b0);
        check_state();

        // randomized matrix patterns against the frame model
        for (int it = 0; it < 12; it++) begin
            pat  = 16'($urandom & $urandom);
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) run_frame(pat, 1'b0);
            check_state();
        end
        repeat (3) run_frame(keys, 1'b0);
        check_state();
        check_irq();
        irq_en = 1'b0;
        check_irq();
        irq_en = 1'b1;
        drain(1);
        drain(2);
        clear_ovf();

        pop1 = 1'b1; @(negedge clk); pop1 = 1'b0;
        chk("empty_pop_count", count1, 0);
        chk("empty_pop_valid", valid1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
